// File: rtl/autosym_pkg.sv
// autosym_pkg: shared types and helpers for the autosymmetry space extractor.
// Holds the controller state encoding, the supported input-width bounds and
// a helper that turns a one-hot member count into its log2.
package autosym_pkg;

  localparam int N_IN_MIN = 2;
  localparam int N_IN_MAX = 10;

  // Wide enough for a member count of up to 2^N_IN_MAX
  localparam int ONEHOT_W = N_IN_MAX + 1;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    SCAN,
    EMIT,
    DONE
  } state_t;

  // Bit position of the single set bit; the member count is always a power of two
  function automatic int onehot_log2(input logic [ONEHOT_W-1:0] v);
    int pos;
    pos = 0;
    for (int i = 0; i < ONEHOT_W; i++) begin
      if (v[i]) pos = i;
    end
    return pos;
  endfunction

endpackage

// File: rtl/autosym_tt_store.sv
// autosym_tt_store: 2^N_IN-entry single-bit truth table of the function under
// test. One synchronous write port filled during sampling, two combinational
// read ports so f(x) and f(x ^ alpha) can be compared in the same cycle.
module autosym_tt_store #(
  parameter int N_IN = 8
) (
  input  logic            clk,
  input  logic            we,
  input  logic [N_IN-1:0] waddr,
  input  logic            wdata,
  input  logic [N_IN-1:0] raddr_a,
  input  logic [N_IN-1:0] raddr_b,
  output logic            rdata_a,
  output logic            rdata_b
);

  logic [(1 << N_IN)-1:0] mem;

  // Capture the function output for the currently applied input vector
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/autosym_space_extractor.sv
// autosym_space_extractor: drives an attached single-output function through
// all 2^N_IN inputs, records its truth table, then streams every alpha of the
// linear space L_f = { a : f(x) = f(x ^ a) for all x } over valid/ready and
// reports dim_k = log2|L_f|.
// Optional build macro AUTOSYM_EARLY_ABORT_EN: a failing alpha is abandoned on
// its first mismatching x; without it every alpha scans the full table so the
// scan time does not depend on the data.
module autosym_space_extractor
  import autosym_pkg::*;
#(
  parameter int N_IN = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [N_IN-1:0]              dut_x,
  input  logic                         dut_y,
  output logic                         busy,
  output logic                         done,
  output logic                         alpha_valid,
  input  logic                         alpha_ready,
  output logic [N_IN-1:0]              alpha,
  output logic [$clog2(N_IN+1)-1:0]    dim_k
);

  localparam int K_W = $clog2(N_IN + 1);
  localparam logic [N_IN-1:0] LAST = '1;

  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_n_in_range
    $error("autosym_space_extractor: N_IN outside supported range");
  end

  state_t          state, state_next;
  logic [N_IN-1:0] x;
  logic [N_IN:0]   count, count_next;
  logic            tt_a, tt_b;
  logic            mismatch, x_last, alpha_last, sample_last, accept;
  logic            scan_pass, scan_fail;

  autosym_tt_store #(.N_IN(N_IN)) u_tt (
    .clk     (clk),
    .we      (state == SAMPLE),
    .waddr   (dut_x),
    .wdata   (dut_y),
    .raddr_a (x),
    .raddr_b (x ^ alpha),
    .rdata_a (tt_a),
    .rdata_b (tt_b)
  );

  assign mismatch    = tt_a ^ tt_b;
  assign x_last      = (x == LAST);
  assign alpha_last  = (alpha == LAST);
  assign sample_last = (dut_x == LAST);
  assign accept      = (state == EMIT) && alpha_ready;
  assign count_next  = accept ? count + (N_IN+1)'(1) : count;

`ifdef AUTOSYM_EARLY_ABORT_EN
  assign scan_fail = mismatch;
  assign scan_pass = x_last && !mismatch;
`else
  logic fail_seen;

  // Remember any earlier mismatch while the current alpha finishes its full scan
  always_ff @(posedge clk) begin
    if (rst)                           fail_seen <= 1'b0;
    else if (state != SCAN || x_last)  fail_seen <= 1'b0;
    else                               fail_seen <= fail_seen | mismatch;
  end

  assign scan_fail = x_last && (fail_seen || mismatch);
  assign scan_pass = x_last && !(fail_seen || mismatch);
`endif

  // Controller state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs; a failing non-final alpha stays in SCAN
  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    alpha_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = SAMPLE;
      end
      SAMPLE: begin
        busy = 1'b1;
        if (sample_last) state_next = EMIT;
      end
      SCAN: begin
        busy = 1'b1;
        if (scan_pass)                     state_next = EMIT;
        else if (scan_fail && alpha_last)  state_next = DONE;
      end
      EMIT: begin
        busy        = 1'b1;
        alpha_valid = 1'b1;
        if (alpha_ready) state_next = alpha_last ? DONE : SCAN;
      end
      DONE: begin
        if (start) state_next = SAMPLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: input sweep, scan index, candidate alpha, member count and result
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_x <= '0;
      x     <= '0;
      alpha <= '0;
      count <= '0;
      dim_k <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dut_x <= '0;
            x     <= '0;
            alpha <= '0;
            count <= '0;
          end
        end
        SAMPLE: begin
          if (!sample_last) dut_x <= dut_x + N_IN'(1);
        end
        SCAN: begin
          x <= x + N_IN'(1);
          if (scan_fail) begin
            x <= '0;
            if (!alpha_last) alpha <= alpha + N_IN'(1);
          end
        end
        EMIT: begin
          if (alpha_ready) begin
            count <= count_next;
            x     <= '0;
            if (!alpha_last) alpha <= alpha + N_IN'(1);
          end
        end
        default: ;
      endcase
      if (state != DONE && state_next == DONE) begin
        done  <= 1'b1;
        dim_k <= K_W'(onehot_log2(ONEHOT_W'(count_next)));
      end
    end
  end

endmodule
